// File: rtl/ema_pkg.sv
// EMA inverse filter shared definitions.
// FSM encoding and datapath widths.
package ema_pkg;

    localparam int DIV_W = 16;
    localparam int NUM_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_udiv.sv
// Iterative restoring unsigned divider.
// One quotient bit per cycle, fixed 16-cycle latency after start.
module seq_udiv
    import ema_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [4:0]       cnt_q;
    logic [DIV_W:0]   rem_sh;
    logic [DIV_W:0]   rem_sub;

    // trial subtraction of the shifted partial remainder
    always_comb begin
        rem_sh  = {rem_q, quo_q[DIV_W-1]};
        rem_sub = rem_sh - {1'b0, divisor};
    end

    // shift/subtract iteration, quotient bits enter from the right
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            cnt_q <= 5'(DIV_W);
        end else if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
            if (!rem_sub[DIV_W]) begin
                rem_q <= rem_sub[DIV_W-1:0];
                quo_q <= {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[DIV_W-1:0];
                quo_q <= {quo_q[DIV_W-2:0], 1'b0};
            end
        end
    end

    // done marks the cycle whose edge writes the last quotient bit
    assign done     = (cnt_q == 5'd1);
    assign quotient = quo_q;

endmodule

// File: rtl/ema_unfilt.sv
// Inverse exponential moving average.
// Recovers x[n] from smoothed y[n] and the previous accepted y.
module ema_unfilt
    import ema_pkg::*;
#(
    parameter int ALPHA  = 25,
    parameter int SCALAR = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       resync,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    if (ALPHA < 1 || ALPHA > SCALAR || SCALAR * 255 >= 65536) begin : g_bad_param
        $fatal(1, "ema_unfilt: illegal ALPHA/SCALAR");
    end

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       samp_q;
    logic [7:0]       yprev_q;
    logic             primed_q;
    logic             first_q;
    logic             div_start;
    logic             div_done;
    logic [DIV_W-1:0] div_quot;
    logic [DIV_W-1:0] dividend;
    logic [NUM_W-1:0] prod_a;
    logic [NUM_W-1:0] prod_b;
    logic [NUM_W-1:0] num;
    logic [7:0]       quot_sat;

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = reset;
                if (in_valid) state_d = ST_CALC;
            end
            ST_CALC: begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = reset;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // sample capture, history and priming
    always_ff @(posedge clk) begin
        if (!reset) begin
            samp_q   <= '0;
            yprev_q  <= '0;
            primed_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                samp_q   <= in_data;
                first_q  <= !primed_q || resync;
                primed_q <= 1'b1;
            end else if (resync) begin
                primed_q <= 1'b0;
            end
            if (state_q == ST_CALC) yprev_q <= samp_q;
        end
    end

    // signed numerator, negative clamps to zero
    always_comb begin
        prod_a = NUM_W'(SCALAR) * NUM_W'(samp_q);
        prod_b = NUM_W'(SCALAR - ALPHA) * NUM_W'(yprev_q);
        num    = prod_a - prod_b;
        if (num[NUM_W-1]) dividend = '0;
        else if (num[DIV_W]) dividend = '1;
        else dividend = num[DIV_W-1:0];
    end

    seq_udiv u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (DIV_W'(ALPHA)),
        .done     (div_done),
        .quotient (div_quot)
    );

    // saturate quotient, first sample passes straight through
    always_comb begin
        quot_sat = (|div_quot[DIV_W-1:8]) ? 8'hFF : div_quot[7:0];
        out_data = 8'd0;
        if (out_valid) out_data = first_q ? samp_q : quot_sat;
    end

endmodule

// File: tb/tb_ema_unfilt.sv
// Self-checking bench for ema_unfilt.
// Reference model computes x from the inverse-EMA formula directly.
module tb_ema_unfilt;

    localparam int A = 25;
    localparam int S = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       resync = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    ema_unfilt #(.ALPHA(A), .SCALAR(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .resync    (resync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_yp = 0;
    bit   m_primed = 0;
    bit   stream = 0;
    bit   have_last = 0;
    int   last_acc = 0;
    bit   lat_done = 0;
    bit   prev_rst_low = 1;

    function automatic int model_x(int y, int yp, bit first);
        int n;
        if (first) return y;
        n = S * y - (S - A) * yp;
        if (n < 0) n = 0;
        n = n / A;
        if (n > 255) n = 255;
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic bad(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // cycle monitor: model update and output comparison
    always @(negedge clk) begin
        bit   first;
        exp_t e;
        cyc++;
        if (!reset) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'(out_data), 0);
            q.delete();
            m_primed = 0;
            m_yp = 0;
            lat_done = 0;
            prev_rst_low = 1;
        end else begin
            if (prev_rst_low) chk("ready_after_reset", int'(in_ready), 1);
            prev_rst_low = 0;
            if (out_valid) begin
                chk("ready_in_done", int'(in_ready), 0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid actual=1 expected=0");
                end else begin
                    chk("out_data", int'(out_data), q[0].x);
                    if (!lat_done) begin
                        chk("latency", cyc - q[0].cyc, 18);
                        lat_done = 1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        lat_done = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                first = !m_primed || resync;
                e.x = model_x(int'(in_data), m_yp, first);
                e.cyc = cyc;
                q.push_back(e);
                m_yp = int'(in_data);
                m_primed = 1;
                if (stream && have_last) chk("spacing", cyc - last_acc, 19);
                last_acc = cyc;
                have_last = 1;
            end else if (resync) begin
                m_primed = 0;
            end
        end
    end

    task automatic send(input logic [7:0] y, input bit rs, input int stall,
                        input int mid_rs);
        bit got;
        @(posedge clk);
        #1;
        in_data = y;
        in_valid = 1'b1;
        resync = rs;
        out_ready = 1'b0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        resync = 1'b0;
        if (!got) begin
            bad("accept_timeout");
            return;
        end
        if (mid_rs > 0) begin
            repeat (mid_rs) @(posedge clk);
            #1 resync = 1'b1;
            @(posedge clk);
            #1 resync = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) begin
            bad("valid_timeout");
            return;
        end
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_stream(input int n_samp);
        int n;
        @(posedge clk);
        #1;
        have_last = 0;
        stream = 1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'($urandom_range(0, 255));
        n = 0;
        for (int i = 0; i < 400 && n < n_samp; i++) begin
            @(negedge clk);
            if (in_ready && in_valid) begin
                n++;
                @(posedge clk);
                #1 in_data = 8'($urandom_range(0, 255));
                if (n == n_samp) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (n < n_samp) bad("stream_timeout");
        repeat (25) @(posedge clk);
        #1;
        out_ready = 1'b0;
        stream = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("pin_first", model_x(100, 0, 1), 100);
        chk("pin_steady", model_x(100, 100, 0), 100);
        chk("pin_sat", model_x(200, 0, 0), 255);
        chk("pin_clamp", model_x(0, 100, 0), 0);
        chk("pin_mid", model_x(120, 100, 0), 180);
        chk("pin_trunc", model_x(101, 100, 0), 104);
        chk("pin_resync", model_x(50, 200, 1), 50);

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        send(8'd100, 0, 0, 0);
        send(8'd100, 0, 0, 0);
        send(8'd0, 0, 0, 0);
        send(8'd200, 0, 0, 0);
        send(8'd100, 0, 0, 0);
        send(8'd0, 0, 0, 0);
        send(8'd200, 0, 10, 0);
        send(8'd50, 1, 0, 0);
        send(8'd120, 0, 2, 0);
        send(8'd80, 0, 0, 5);
        send(8'd90, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            send(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0);
        end

        run_stream(6);

        @(posedge clk);
        #1;
        in_data = 8'd33;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(posedge clk);
        send(8'd77, 0, 0, 0);
        send(8'd77, 0, 0, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
